// File: rtl/busio_data.sv
// busio_data: data-side bus responder between the memory stage and a 32-bit
// req/ack word bus. Each load/store becomes exactly one bus transaction. Loads
// return lane-aligned, sign/zero-extended data. mem_busy stalls the pipeline
// until the result is ready.
// Optional feature macro: BUSIO_TIMEOUT_EN. When it is defined, a REQ that
// sees no ack for TIMEOUT_CYCLES cycles is aborted and mem_fault is raised.
module busio_data #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_store_data,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic        advance,
   output logic [31:0] mem_load_data,
   output logic        mem_busy,
   output logic        mem_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [1:0]  lane_r;
   logic [1:0]  size_r;
   logic        signed_r;
   logic        req_s;
   logic        start_s;
   logic        finish_s;
   logic        expire_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;

   // Shift the raw word down to its lane, then extend from bit 7 or bit 15.
   function automatic logic [31:0] load_extend(
      input logic [31:0] raw,
      input logic [1:0]  lane,
      input logic [1:0]  size,
      input logic        sgn
   );
      logic [31:0] sh;
      logic [31:0] res;
      sh = raw >> {lane, 3'b000};
      case (size)
         2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
         2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   assign req_s    = mem_load | mem_store;
   assign start_s  = (state_r == IDLE) && req_s;
   assign finish_s = (state_r == REQ) && (bus_ack || expire_s);

   // Byte enables and lane-replicated write data for the incoming request.
   always_comb begin
      be_s    = 4'b1111;
      wdata_s = mem_store_data;
      case (mem_size)
         2'b00: begin
            be_s    = 4'b0001 << mem_address[1:0];
            wdata_s = {4{mem_store_data[7:0]}};
         end
         2'b01: begin
            be_s    = 4'b0011 << mem_address[1:0];
            wdata_s = {2{mem_store_data[15:0]}};
         end
         default: begin
            be_s    = 4'b1111;
            wdata_s = mem_store_data;
         end
      endcase
   end

`ifdef BUSIO_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] tmo_cnt_r;

   // Abort on the last allowed REQ cycle unless the ack arrives in it.
   assign expire_s = (state_r == REQ) && !bus_ack &&
                     (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count REQ cycles without ack; cleared when a transaction starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= '0;
      end else if (start_s) begin
         tmo_cnt_r <= '0;
      end else if ((state_r == REQ) && !bus_ack) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end
   end

   // Fault flag: set by an abort, cleared when DONE is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_fault <= 1'b0;
      end else if (expire_s) begin
         mem_fault <= 1'b1;
      end else if ((state_r == DONE) && advance) begin
         mem_fault <= 1'b0;
      end
   end
`else
   assign expire_s  = 1'b0;
   assign mem_fault = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and stall decode.
   always_comb begin
      state_s  = state_r;
      mem_busy = 1'b0;
      case (state_r)
         IDLE: begin
            mem_busy = req_s;
            if (req_s) begin
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            mem_busy = 1'b1;
            if (bus_ack || expire_s) begin
               state_s = DONE;
            end else begin
               state_s = REQ;
            end
         end
         DONE: begin
            mem_busy = 1'b0;
            if (advance) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            mem_busy = 1'b0;
            state_s  = IDLE;
         end
      endcase
   end

   // Bus request fields: captured at request time, stable through REQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0000_0000;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'h0000_0000;
         lane_r    <= 2'b00;
         size_r    <= 2'b00;
         signed_r  <= 1'b0;
      end else if (start_s) begin
         bus_req   <= 1'b1;
         bus_we    <= mem_store;
         bus_addr  <= {mem_address[31:2], 2'b00};
         bus_be    <= be_s;
         bus_wdata <= wdata_s;
         lane_r    <= mem_address[1:0];
         size_r    <= mem_size;
         signed_r  <= mem_signed;
      end else if (finish_s) begin
         bus_req   <= 1'b0;
      end
   end

   // Load result: extended read data on ack (0 for stores), 0 on abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_load_data <= 32'h0000_0000;
      end else if ((state_r == REQ) && bus_ack) begin
         if (bus_we) begin
            mem_load_data <= 32'h0000_0000;
         end else begin
            mem_load_data <= load_extend(bus_rdata, lane_r, size_r, signed_r);
         end
      end else if (expire_s) begin
         mem_load_data <= 32'h0000_0000;
      end
   end

endmodule
